// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op encoding, occupancy state and result flags.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_NOT_B = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation plus status flags of the result.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XNOR:  result = ~(a ^ b);
            OP_NOT_A: result = ~a;
            OP_NOT_B: result = ~b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags.zero   = ~|result;
        flags.ones   = &result;
        flags.parity = ^result;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: result stage plus one skid entry behind a valid/ready handshake.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [WIDTH-1:0] core_result;
    flags_t           core_flags;

    occ_e             state_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] out_data_q;
    flags_t           out_flags_q;
    logic [WIDTH-1:0] skid_data_q;
    flags_t           skid_flags_q;
    logic [CNT_W-1:0] xfer_cnt_q;

    logic accept;
    logic drain;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (in_a),
        .b      (in_b),
        .op     (in_op),
        .result (core_result),
        .flags  (core_flags)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != EMPTY) & out_ready;

    // in_ready is registered from the next state, so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_data_q   <= '0;
            out_flags_q  <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            xfer_cnt_q   <= '0;
        end else begin
            in_ready_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_data_q  <= core_result;
                        out_flags_q <= core_flags;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        out_data_q  <= core_result;
                        out_flags_q <= core_flags;
                    end else if (accept) begin
                        skid_data_q  <= core_result;
                        skid_flags_q <= core_flags;
                        state_q      <= TWO;
                        in_ready_q   <= 1'b0;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        out_data_q  <= skid_data_q;
                        out_flags_q <= skid_flags_q;
                        state_q     <= ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase

            if (drain) begin
                xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = out_data_q;
    assign out_zero   = out_flags_q.zero;
    assign out_ones   = out_flags_q.ones;
    assign out_parity = out_flags_q.parity;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model plus directed literal checks.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid, out_zero, out_ones, out_parity;
    logic [7:0]  out_data;
    logic [15:0] xfer_cnt;

    logic        in_ready4, out_valid4, out_zero4, out_ones4, out_parity4;
    logic [7:0]  out_data4;
    logic [3:0]  xfer_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    int unsigned mcnt = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity), .xfer_cnt(xfer_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_zero(out_zero4),
        .out_ones(out_ones4), .out_parity(out_parity4), .xfer_cnt(xfer_cnt4)
    );

    function automatic logic [7:0] model_op(logic [7:0] a, logic [7:0] b, int op);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return ~a;
            default: return ~b;
        endcase
    endfunction

    function automatic logic model_parity(logic [7:0] r);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(r[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a 2-deep FIFO; ready while fewer than two results are held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit acc;
            bit drn;
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (drn) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (acc) mq.push_back(model_op(in_a, in_b, int'(in_op)));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(1));
            check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        end else begin
            check("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("m_cnt16", 32'(xfer_cnt), 32'(mcnt % 65536));
            check("m_cnt4", 32'(xfer_cnt4), 32'(mcnt % 16));
            if (mq.size() > 0) begin
                check("m_out_data", 32'(out_data), 32'(mq[0]));
                check("m_zero", 32'(out_zero), 32'(mq[0] == 8'h00));
                check("m_ones", 32'(out_ones), 32'(mq[0] == 8'hFF));
                check("m_parity", 32'(out_parity), 32'(model_parity(mq[0])));
            end
        end
    end

    task automatic send_check(logic [7:0] a, logic [7:0] b, logic [2:0] op,
                              logic [7:0] exp_d, logic ez, logic eo, logic ep);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(negedge clk);
        in_valid = 1'b0;
        check("flag_data", 32'(out_data), 32'(exp_d));
        check("flag_zero", 32'(out_zero), 32'(ez));
        check("flag_ones", 32'(out_ones), 32'(eo));
        check("flag_parity", 32'(out_parity), 32'(ep));
    endtask

    task automatic stream(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            in_op = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] sweep [8];
        sweep = '{8'h04, 8'hFD, 8'hF9, 8'hFB, 8'h02, 8'h06, 8'h3A, 8'hC3};

        repeat (3) @(negedge clk);
        check("reset_out_data", 32'(out_data), 32'(0));
        check("reset_flags", 32'({out_zero, out_ones, out_parity}), 32'(0));
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Op sweep, one result per cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) check("sweep_data", 32'(out_data), 32'(sweep[k-1]));
            in_valid = 1'b1; in_a = 8'hC5; in_b = 8'h3C; in_op = 3'(k);
        end
        @(negedge clk);
        check("sweep_data", 32'(out_data), 32'(sweep[7]));
        check("sweep_valid", 32'(out_valid), 32'(1));
        in_valid = 1'b0;

        send_check(8'h00, 8'h00, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0);
        send_check(8'hFF, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b1, 1'b0);
        send_check(8'h01, 8'h00, 3'd1, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Backpressure: three back-to-back with the sink stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 3'd1;
        @(negedge clk);
        check("bp_ready_one", 32'(in_ready), 32'(1));
        in_a = 8'hF0; in_b = 8'h0F; in_op = 3'd2;
        @(negedge clk);
        check("bp_ready_two", 32'(in_ready), 32'(0));
        in_a = 8'hAA; in_b = 8'h00; in_op = 3'd6;
        @(negedge clk);
        check("bp_ready_hold", 32'(in_ready), 32'(0));
        check("bp_stable", 32'(out_data), 32'(8'h33));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second", 32'(out_data), 32'(8'hFF));
        check("bp_ready_back", 32'(in_ready), 32'(1));
        @(negedge clk);
        check("bp_third", 32'(out_data), 32'(8'h55));
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'(0));

        // Asynchronous reset with the skid full
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h0F; in_op = 3'd6;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("async_in_ready", 32'(in_ready), 32'(1));
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("async_cnt", 32'(xfer_cnt), 32'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        stream(100);
        check("stream_cnt16", 32'(xfer_cnt), 32'(100));
        check("stream_cnt4", 32'(xfer_cnt4), 32'(4));

        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        stream(17);
        check("wrap_cnt4", 32'(xfer_cnt4), 32'(1));
        check("wrap_cnt16", 32'(xfer_cnt), 32'(17));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's two-input combinational gate block.
- Applies one of eight bitwise operations, selected per transaction, to two WIDTH-bit operands.
- Results pass through a valid/ready handshaked pipeline with a 2-entry skid buffer, so the upstream ready has no combinational path from the downstream ready.
- Also produces per-result status flags and a transfer counter; used wherever a gate function must sit in a flow-controlled datapath.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- CNT_W, 16, width of the completed-transfer counter (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block can accept; registered
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  operation select (package encoding)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  result
- out_zero  out  1  result == 0
- out_ones  out  1  result == all ones
- out_parity  out  1  XOR-reduction of result
- xfer_cnt  out  CNT_W  count of output handshakes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, and on its release: out_valid=0, out_data=0, all flags=0, xfer_cnt=0, skid empty, in_ready=1.
- Op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR (all bitwise).
  - 6 NOT_A = ~in_a; 7 NOT_B = ~in_b.
  - Result width is always WIDTH. No sign or carry semantics.
- Flags are computed from the result in the same stage and travel with it.
- Input handshake: accepted when in_valid & in_ready at a clock edge. The op is sampled with the operands.
- Output handshake: completes when out_valid & out_ready at a clock edge.
- Latency: an accepted input appears on out_* the next cycle when the output stage is empty or draining. Throughput is 1 per cycle while out_ready=1.
- States (occupancy):
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - TWO: out_valid=1, skid full.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & out_ready -> ONE (output register reloads). Accept & !out_ready -> TWO (new result goes to skid). No accept & out_ready -> EMPTY. Otherwise hold.
  - TWO: in_ready=0, so no accept. out_ready -> ONE (skid moves to output register). Otherwise hold.
- in_ready is a registered function of state: 0 only in TWO. It must not depend on out_ready in the same cycle.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data and flags are stable.
- xfer_cnt increments by 1 on each output handshake and wraps from all-ones to 0.
- in_op values are fully decoded. X/Z on in_op when in_valid=0 has no effect.
- Reset mid-operation: pending results in the output register and skid are discarded. in_ready returns to 1 immediately, asynchronously.
- WIDTH=1 is legal. out_zero and out_ones are then complements of each other.

Decomposition:
- Package logic_unit_pkg:
  - 3-bit op enum (OP_AND..OP_NOT_B).
  - Occupancy-state enum (EMPTY/ONE/TWO).
  - A flags struct {zero, ones, parity}.
- Sub-module logic_unit_core: purely combinational. Inputs a, b, op; outputs result and flags; parametrised by WIDTH.
- The top level holds the skid/output registers, the state machine and the counter.

Test Plan:
- Reset, WIDTH=8: assert rst mid-stream -> out_valid=0, in_ready=1, xfer_cnt=0 while rst is high.
- Op sweep: in_a=0xC5, in_b=0x3C, op 0..7 with out_ready=1 -> out_data 0x04, 0xFD, 0xF9, 0xFB, 0x02, 0x06, 0x3A, 0xC3 on consecutive cycles, one cycle after each accept.
- Flags:
  - a=0x00, b=0x00, OR -> zero=1, ones=0, parity=0.
  - a=0xFF, NOT_B with b=0x00 -> ones=1.
  - a=0x01, b=0x00, OR -> parity=1.
- Backpressure: out_ready=0, send 3 back-to-back -> first two accepted, in_ready=0 after the second. Raise out_ready -> results emerge in order with no loss. in_ready returns to 1 the cycle after the first drain.
- Streaming: out_ready=1, 100 continuous inputs -> 100 outputs, one per cycle after the first, xfer_cnt=100.
- Counter wrap, CNT_W=4: 17 transfers -> xfer_cnt=1.
